ex_mdu: RTL and testbench

Multiply/divide unit for the EX stage of the pipelined MIPS core, directly downstream of the ID/EX pipeline register. It consumes the operand pair (RD1/RD2) and a decoded MDU opcode for the instruction in EX, runs multi-cycle mult/div with a busy window, and owns the architectural HI/LO registers. It also drives the stall request that the hazard unit uses to hold MDU instructions in ID, and honours an exception cancel so that an instruction being flushed never alters HI/LO.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_calc.sv | 64 ++++++
 rtl/ex_mdu.sv | 123 ++++++++++++
 tb/tb_ex_mdu.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: opcodes, FSM states, default latencies.
package mdu_pkg;

  localparam int unsigned MDOP_W          = 4;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic [MDOP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } mdop_e;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } mdu_state_e;

  function automatic logic is_start(input mdop_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mult(input mdop_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit signed/unsigned product and 32-bit quotient/remainder.
module mdu_calc
  import mdu_pkg::*;
(
  input  mdop_e       op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        valid
);

  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_div;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign sgn   = (op == MD_MULT) || (op == MD_DIV);
  assign a_neg = sgn & a[31];
  assign b_neg = sgn & b[31];

  // Low 64 bits of the sign-extended product equal the signed product.
  assign a_ext = {{32{a_neg}}, a};
  assign b_ext = {{32{b_neg}}, b};
  assign prod  = a_ext * b_ext;

  // Sign-magnitude divide keeps 0x80000000 / -1 well defined (magnitude 2^31 fits unsigned).
  assign a_mag = a_neg ? (32'd0 - a) : a;
  assign b_mag = b_neg ? (32'd0 - b) : b;
  assign b_div = (b == '0) ? 32'd1 : b_mag;
  assign q_mag = a_mag / b_div;
  assign r_mag = a_mag % b_div;
  assign quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    hi    = '0;
    lo    = '0;
    valid = 1'b0;
    case (op)
      MD_MULT, MD_MULTU: begin
        hi    = prod[63:32];
        lo    = prod[31:0];
        valid = 1'b1;
      end
      MD_DIV, MD_DIVU: begin
        hi    = rem;
        lo    = quot;
        valid = (b != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multiply/divide unit: multi-cycle mult/div with busy window, owns HI/LO.
module ex_mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [MDOP_W-1:0] MDOp,
  input  logic              MDCancel,
  input  logic [31:0]       MDA,
  input  logic [31:0]       MDB,
  output logic              MDBusy,
  output logic              MDStallReq,
  output logic [31:0]       MDOut,
  output logic [31:0]       HI,
  output logic [31:0]       LO
);

  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  mdop_e      op;
  mdu_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       start;
  logic       done;
  logic       idle_ok;

  logic [31:0] c_hi, c_lo;
  logic        c_valid;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic        pend_wr_q;
  logic [31:0] hi_q, lo_q;

  assign op = mdop_e'(MDOp);

  mdu_calc u_calc (
    .op    (op),
    .a     (MDA),
    .b     (MDB),
    .hi    (c_hi),
    .lo    (c_lo),
    .valid (c_valid)
  );

  always_comb begin
    idle_ok = (state_q == S_IDLE) && !MDCancel;
    start   = idle_ok && is_start(op);
    done    = (state_q == S_BUSY) && (cnt_q == 4'd1);
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_BUSY;
          cnt_d   = is_mult(op) ? MULT_LD : DIV_LD;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result is captured at start; a divide by zero commits nothing at completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (start) begin
        pend_hi_q <= c_hi;
        pend_lo_q <= c_lo;
        pend_wr_q <= c_valid;
      end
      if (done) begin
        if (pend_wr_q) begin
          hi_q <= pend_hi_q;
          lo_q <= pend_lo_q;
        end
      end else if (idle_ok) begin
        if (op == MD_MTHI) hi_q <= MDA;
        if (op == MD_MTLO) lo_q <= MDA;
      end
    end
  end

  assign MDBusy     = (state_q == S_BUSY);
  assign MDStallReq = MDBusy | start;
  assign HI         = hi_q;
  assign LO         = lo_q;

  always_comb begin
    MDOut = '0;
    if (op == MD_MFHI) MDOut = hi_q;
    if (op == MD_MFLO) MDOut = lo_q;
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Directed self-checking bench for ex_mdu with hand-computed HI/LO expectations.
module tb_ex_mdu;
  import mdu_pkg::*;

  logic              clk;
  logic              reset;
  logic [MDOP_W-1:0] MDOp;
  logic              MDCancel;
  logic [31:0]       MDA;
  logic [31:0]       MDB;
  logic              MDBusy;
  logic              MDStallReq;
  logic [31:0]       MDOut;
  logic [31:0]       HI;
  logic [31:0]       LO;

  int unsigned nchecks = 0;
  int unsigned nerrors = 0;

  ex_mdu #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MDOp       (MDOp),
    .MDCancel   (MDCancel),
    .MDA        (MDA),
    .MDB        (MDB),
    .MDBusy     (MDBusy),
    .MDStallReq (MDStallReq),
    .MDOut      (MDOut),
    .HI         (HI),
    .LO         (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp)
    else begin
      nerrors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    check({tag, "_hi"}, HI, exp_hi);
    check({tag, "_lo"}, LO, exp_lo);
  endtask

  // Called at a negedge; presents the op for one cycle and returns at the negedge after E0.
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    MDOp = op;
    MDA  = a;
    MDB  = b;
    #1;
    check({tag, "_stallreq"}, 32'(MDStallReq), 32'd1);
    @(negedge clk);
    MDOp = MD_NONE;
  endtask

  // Counts negedges with MDBusy high; bounded so a stuck busy still reaches the summary.
  task automatic busy_window(input string tag, input int unsigned n);
    int unsigned cnt;
    cnt = 0;
    while (MDBusy === 1'b1 && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    check({tag, "_busycycles"}, cnt, n);
  endtask

  initial begin
    reset    = 1'b0;
    MDOp     = MD_NONE;
    MDCancel = 1'b0;
    MDA      = '0;
    MDB      = '0;
    repeat (2) @(negedge clk);
    check_hilo("reset", 32'h0, 32'h0);
    check("reset_busy", 32'(MDBusy), 32'd0);
    check("reset_mdout", MDOut, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Reset in the middle of MULT 3x4
    issue("rst_mult", MD_MULT, 32'd3, 32'd4);
    check("rst_mult_busy", 32'(MDBusy), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_hilo("rst_mid", 32'h0, 32'h0);
    check("rst_mid_busy", 32'(MDBusy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check_hilo("rst_after", 32'h0, 32'h0);
    check("rst_after_busy", 32'(MDBusy), 32'd0);

    issue("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3);
    busy_window("mult", 5);
    check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    issue("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3);
    busy_window("multu", 5);
    check_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

    issue("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2);
    busy_window("div_m7_2", 10);
    check_hilo("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue("div_7_m2", MD_DIV, 32'd7, 32'hFFFF_FFFE);
    busy_window("div_7_m2", 10);
    check_hilo("div_7_m2", 32'h0000_0001, 32'hFFFF_FFFD);

    issue("divu_big", MD_DIVU, 32'hFFFF_FFFF, 32'h10);
    busy_window("divu_big", 10);
    check_hilo("divu_big", 32'h0000_000F, 32'h0FFF_FFFF);

    issue("divu_zero", MD_DIVU, 32'd7, 32'd0);
    busy_window("divu_zero", 10);
    check_hilo("divu_zero", 32'h0000_000F, 32'h0FFF_FFFF);

    // Cancelled MULT: no start
    MDOp = MD_MULT; MDA = 32'd5; MDB = 32'd6; MDCancel = 1'b1;
    #1;
    check("cancel_mult_stallreq", 32'(MDStallReq), 32'd0);
    @(negedge clk);
    MDOp = MD_NONE; MDCancel = 1'b0;
    check("cancel_mult_busy", 32'(MDBusy), 32'd0);
    check_hilo("cancel_mult", 32'h0000_000F, 32'h0FFF_FFFF);

    // Cancelled MTLO
    MDOp = MD_MTLO; MDA = 32'h1234; MDCancel = 1'b1;
    @(negedge clk);
    MDOp = MD_NONE; MDCancel = 1'b0;
    check("cancel_mtlo_lo", LO, 32'h0FFF_FFFF);

    MDOp = MD_MTLO; MDA = 32'h1234;
    #1;
    check("mtlo_mdout_same", MDOut, 32'h0);
    check("mtlo_stallreq", 32'(MDStallReq), 32'd0);
    @(negedge clk);
    MDOp = MD_MFLO;
    #1;
    check("mflo_mdout", MDOut, 32'h1234);
    check("mtlo_lo", LO, 32'h1234);
    check("mtlo_busy", 32'(MDBusy), 32'd0);
    MDOp = MD_MFHI;
    #1;
    check("mfhi_mdout", MDOut, 32'h0000_000F);
    @(negedge clk);

    // MTHI presented while BUSY must be ignored
    issue("mult_mthi", MD_MULT, 32'h10, 32'h20);
    MDOp = MD_MTHI; MDA = 32'h55;
    @(negedge clk);
    MDOp = MD_NONE;
    check("mthi_busy_hi", HI, 32'h0000_000F);
    busy_window("mult_mthi", 4);
    check_hilo("mult_mthi", 32'h0, 32'h200);

    // Back-to-back: DIV in the first cycle with MDBusy low
    check("b2b_busy_low", 32'(MDBusy), 32'd0);
    issue("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_window("div_ovf", 10);
    check_hilo("div_ovf", 32'h0, 32'h8000_0000);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
